// File: rtl/tbec_scrubber.sv
// TBEC background scrubber with its encoder/decoder: walks the memory, rewrites
// correctable words with a clean encoding and keeps error statistics.

module tbec_encoder (
  input  logic [15:0] data_i,
  output logic [31:0] code_o
);
  // Extended Hamming(22,16): check bits at positions 1,2,4,8,16, overall parity at bit 0, bits 31:22 zero
  localparam logic [4:0] DPOS [16] = '{5'd3, 5'd5, 5'd6, 5'd7, 5'd9, 5'd10, 5'd11, 5'd12,
                                       5'd13, 5'd14, 5'd15, 5'd17, 5'd18, 5'd19, 5'd20, 5'd21};

  logic [31:0] cw;
  logic [4:0]  chk;

  always_comb begin
    cw  = '0;
    chk = '0;
    for (int i = 0; i < 16; i++) cw[DPOS[i]] = data_i[i];
    for (int p = 1; p < 22; p++) if (cw[p]) chk = chk ^ 5'(p);
    cw[1]  = chk[0];
    cw[2]  = chk[1];
    cw[4]  = chk[2];
    cw[8]  = chk[3];
    cw[16] = chk[4];
    cw[0]  = ^cw[21:1];
  end

  assign code_o = cw;
endmodule

module tbec_decoder (
  input  logic [31:0] code_i,
  output logic [15:0] data_o,
  output logic [1:0]  error_code_o
);
  localparam logic [4:0] DPOS [16] = '{5'd3, 5'd5, 5'd6, 5'd7, 5'd9, 5'd10, 5'd11, 5'd12,
                                       5'd13, 5'd14, 5'd15, 5'd17, 5'd18, 5'd19, 5'd20, 5'd21};

  logic [4:0] syndrome;
  logic       overall;
  logic [9:0] pad;
  logic       padErr;
  logic       padSingle;
  logic       dataFix;

  always_comb begin
    syndrome = '0;
    for (int p = 1; p < 22; p++) if (code_i[p]) syndrome = syndrome ^ 5'(p);
  end

  assign overall   = ^code_i[21:0];
  assign pad       = code_i[31:22];
  assign padErr    = |pad;
  assign padSingle = padErr && ((pad & (pad - 10'd1)) == 10'd0);
  assign dataFix   = overall && (syndrome <= 5'd21) && !padErr;

  // A lone flip in the unused pad bits is correctable: re-encoding clears it
  always_comb begin
    error_code_o = 2'b00;
    if (!overall && syndrome == 5'd0) begin
      if (padErr) error_code_o = padSingle ? 2'b01 : 2'b11;
    end else if (dataFix) begin
      error_code_o = 2'b01;
    end else if (!overall) begin
      error_code_o = 2'b10;
    end else begin
      error_code_o = 2'b11;
    end
  end

  always_comb begin
    data_o = '0;
    for (int i = 0; i < 16; i++)
      data_o[i] = code_i[DPOS[i]] ^ (dataFix && (syndrome == DPOS[i]));
  end
endmodule

module tbec_scrubber #(
  parameter int DEPTH  = 256,
  parameter int ADDR_W = 8,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              pause,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  corr_count,
  output logic [CNT_W-1:0]  uncorr_count,
  output logic [ADDR_W-1:0] last_err_addr,
  output logic              err_irq
);
  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_READ  = 3'd1;
  localparam logic [2:0] S_CHECK = 3'd2;
  localparam logic [2:0] S_WRITE = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

  logic [2:0]        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [CNT_W-1:0]  corrCount_q, corrCount_d;
  logic [CNT_W-1:0]  uncorrCount_q, uncorrCount_d;
  logic [ADDR_W-1:0] lastErrAddr_q, lastErrAddr_d;
  logic              errIrq_q, errIrq_d;
  logic [31:0]       wdata_q, wdata_d;

  logic [15:0] decData;
  logic [1:0]  errCode;
  logic [31:0] encWord;
  logic        advanceDone;

  tbec_decoder uDecoder (
    .code_i       (mem_rdata),
    .data_o       (decData),
    .error_code_o (errCode)
  );

  tbec_encoder uEncoder (
    .data_i (decData),
    .code_o (encWord)
  );

  assign advanceDone = (addr_q == LAST_ADDR);

  always_comb begin
    state_d       = state_q;
    addr_d        = addr_q;
    corrCount_d   = corrCount_q;
    uncorrCount_d = uncorrCount_q;
    lastErrAddr_d = lastErrAddr_q;
    errIrq_d      = errIrq_q;
    wdata_d       = wdata_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d       = S_READ;
          addr_d        = '0;
          corrCount_d   = '0;
          uncorrCount_d = '0;
          errIrq_d      = 1'b0;
        end
      end
      S_READ: begin
        if (!pause) state_d = S_CHECK;
      end
      S_CHECK: begin
        state_d = advanceDone ? S_DONE : S_READ;
        if (!advanceDone) addr_d = addr_q + ADDR_W'(1);
        if (errCode == 2'b01) begin
          // Hold the address: the corrected word goes back to the same location
          state_d       = S_WRITE;
          addr_d        = addr_q;
          wdata_d       = encWord;
          lastErrAddr_d = addr_q;
          if (corrCount_q != CNT_MAX) corrCount_d = corrCount_q + CNT_W'(1);
        end else if (errCode[1]) begin
          lastErrAddr_d = addr_q;
          errIrq_d      = 1'b1;
          if (uncorrCount_q != CNT_MAX) uncorrCount_d = uncorrCount_q + CNT_W'(1);
        end
      end
      S_WRITE: begin
        state_d = advanceDone ? S_DONE : S_READ;
        if (!advanceDone) addr_d = addr_q + ADDR_W'(1);
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= S_IDLE;
      addr_q        <= '0;
      corrCount_q   <= '0;
      uncorrCount_q <= '0;
      lastErrAddr_q <= '0;
      errIrq_q      <= 1'b0;
      wdata_q       <= '0;
    end else begin
      state_q       <= state_d;
      addr_q        <= addr_d;
      corrCount_q   <= corrCount_d;
      uncorrCount_q <= uncorrCount_d;
      lastErrAddr_q <= lastErrAddr_d;
      errIrq_q      <= errIrq_d;
      wdata_q       <= wdata_d;
    end
  end

  assign mem_req       = ((state_q == S_READ) && !pause) || (state_q == S_CHECK) || (state_q == S_WRITE);
  assign mem_addr      = mem_req ? addr_q : '0;
  assign mem_we        = (state_q == S_WRITE);
  assign mem_wdata     = (state_q == S_WRITE) ? wdata_q : '0;
  assign busy          = (state_q == S_READ) || (state_q == S_CHECK) || (state_q == S_WRITE);
  assign done          = (state_q == S_DONE);
  assign corr_count    = corrCount_q;
  assign uncorr_count  = uncorrCount_q;
  assign last_err_addr = lastErrAddr_q;
  assign err_irq       = errIrq_q;
endmodule

// File: tb/tb_tbec_scrubber.sv
// Directed bench for tbec_scrubber: a full-size instance for the pass scenarios
// and a tiny CNT_W=2 instance for counter saturation.

module tb_tbec_scrubber;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, start, pause, start2;
  logic        memReq, memWe, busy, done, errIrq;
  logic [7:0]  memAddr, lastErrAddr;
  logic [31:0] memWdata, memRdata;
  logic [15:0] corrCount, uncorrCount;
  logic        memReq2, memWe2, busy2, done2, errIrq2;
  logic [2:0]  memAddr2, lastErrAddr2;
  logic [31:0] memWdata2, memRdata2;
  logic [1:0]  corrCount2, uncorrCount2;

  logic [31:0] mem   [256];
  logic [31:0] orig  [256];
  logic [31:0] mem2  [8];
  logic [31:0] orig2 [8];
  logic [15:0] encData;
  logic [31:0] encWord;

  int          cmpCount = 0;
  int          errCount = 0;
  int          nWrites, nWrites2, doneEdge, doneEdge2, pauseViol;
  logic        resumeReq, startReq, startIrq;
  logic [7:0]  resumeAddr, startAddr, lastWrAddr;
  logic [31:0] lastWrData;

  assign memRdata  = mem[memAddr];
  assign memRdata2 = mem2[memAddr2];

  tbec_encoder uEnc (.data_i(encData), .code_o(encWord));

  tbec_scrubber #(.DEPTH(256), .ADDR_W(8), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .start(start), .pause(pause),
    .mem_req(memReq), .mem_addr(memAddr), .mem_we(memWe), .mem_wdata(memWdata),
    .mem_rdata(memRdata), .busy(busy), .done(done), .corr_count(corrCount),
    .uncorr_count(uncorrCount), .last_err_addr(lastErrAddr), .err_irq(errIrq)
  );

  tbec_scrubber #(.DEPTH(8), .ADDR_W(3), .CNT_W(2)) dutSat (
    .clk(clk), .rst(rst), .start(start2), .pause(1'b0),
    .mem_req(memReq2), .mem_addr(memAddr2), .mem_we(memWe2), .mem_wdata(memWdata2),
    .mem_rdata(memRdata2), .busy(busy2), .done(done2), .corr_count(corrCount2),
    .uncorr_count(uncorrCount2), .last_err_addr(lastErrAddr2), .err_irq(errIrq2)
  );

  // Memory writes land mid-cycle; afterwards everything is observed 1 ns past the edge
  task automatic tick;
    @(negedge clk);
    if (memReq && memWe) begin
      mem[memAddr] = memWdata;
      nWrites++;
      lastWrAddr = memAddr;
      lastWrData = memWdata;
    end
    if (memReq2 && memWe2) begin
      mem2[memAddr2] = memWdata2;
      nWrites2++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic fillMemory;
    for (int a = 0; a < 256; a++) begin
      encData = 16'(a * 40503 + 4660);
      #1;
      mem[a]  = encWord;
      orig[a] = encWord;
    end
  endtask

  // Edge e is the e-th rising edge after the one sampling start; pause is held for edges [pauseFrom, pauseFrom+pauseLen)
  task automatic runPass(input int pauseFrom, input int pauseLen);
    tick;
    nWrites   = 0;
    pauseViol = 0;
    doneEdge  = -1;
    resumeReq = 1'b0;
    resumeAddr = '0;
    start = 1'b1;
    tick;
    start = 1'b0;
    startReq  = memReq;
    startAddr = memAddr;
    startIrq  = errIrq;
    for (int e = 1; e <= 700; e++) begin
      pause = (e >= pauseFrom) && (e < pauseFrom + pauseLen);
      #1;
      if (pause && memReq) pauseViol++;
      if (e == pauseFrom + pauseLen) begin
        resumeReq  = memReq;
        resumeAddr = memAddr;
      end
      tick;
      if (done) begin
        doneEdge = e;
        break;
      end
    end
    pause = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b0; start = 1'b0; start2 = 1'b0; pause = 1'b0;
    nWrites = 0; nWrites2 = 0;
    tick;
    tick;
    cmpCount++;
    if ({memReq, memWe, memAddr, memWdata} !== 42'd0) begin
      errCount++; $display("[TB] FAIL reset_memport: got %h, expected 0", {memReq, memWe, memAddr, memWdata});
    end
    cmpCount++;
    if ({busy, done, corrCount, uncorrCount, lastErrAddr, errIrq} !== 43'd0) begin
      errCount++; $display("[TB] FAIL reset_status: got %h, expected 0", {busy, done, corrCount, uncorrCount, lastErrAddr, errIrq});
    end
    cmpCount++;
    if ({memReq2, busy2, done2, corrCount2, uncorrCount2, errIrq2} !== 8'd0) begin
      errCount++; $display("[TB] FAIL reset_sat_status: got %h, expected 0", {memReq2, busy2, done2, corrCount2, uncorrCount2, errIrq2});
    end
    rst = 1'b1;
    tick;
  endtask

  task automatic test_clean_pass;
    fillMemory;
    runPass(0, 0);
    cmpCount++;
    if (startReq !== 1'b1 || startAddr !== 8'd0) begin
      errCount++; $display("[TB] FAIL clean_first_read: got req %b addr %0d, expected req 1 addr 0", startReq, startAddr);
    end
    cmpCount++;
    if (doneEdge !== 512) begin
      errCount++; $display("[TB] FAIL clean_done_edge: got %0d, expected 512", doneEdge);
    end
    cmpCount++;
    if (corrCount !== 16'd0 || uncorrCount !== 16'd0 || errIrq !== 1'b0) begin
      errCount++; $display("[TB] FAIL clean_stats: got corr %0d uncorr %0d irq %b, expected 0 0 0", corrCount, uncorrCount, errIrq);
    end
    cmpCount++;
    if (nWrites !== 0) begin
      errCount++; $display("[TB] FAIL clean_no_write: got %0d writes, expected 0", nWrites);
    end
  endtask

  task automatic test_single_flip;
    mem[8'h2A] = mem[8'h2A] ^ 32'h0000_0080;
    runPass(0, 0);
    cmpCount++;
    if (doneEdge !== 513) begin
      errCount++; $display("[TB] FAIL flip_done_edge: got %0d, expected 513", doneEdge);
    end
    cmpCount++;
    if (corrCount !== 16'd1 || uncorrCount !== 16'd0) begin
      errCount++; $display("[TB] FAIL flip_counts: got corr %0d uncorr %0d, expected 1 0", corrCount, uncorrCount);
    end
    cmpCount++;
    if (nWrites !== 1 || lastWrAddr !== 8'h2A) begin
      errCount++; $display("[TB] FAIL flip_write_addr: got %0d writes last addr %h, expected 1 at 2a", nWrites, lastWrAddr);
    end
    cmpCount++;
    if (lastWrData !== orig[8'h2A]) begin
      errCount++; $display("[TB] FAIL flip_write_data: got %h, expected %h", lastWrData, orig[8'h2A]);
    end
    cmpCount++;
    if (lastErrAddr !== 8'h2A) begin
      errCount++; $display("[TB] FAIL flip_last_err_addr: got %h, expected 2a", lastErrAddr);
    end
    runPass(0, 0);
    cmpCount++;
    if (corrCount !== 16'd0 || doneEdge !== 512 || nWrites !== 0) begin
      errCount++; $display("[TB] FAIL flip_second_pass: got corr %0d done %0d writes %0d, expected 0 512 0", corrCount, doneEdge, nWrites);
    end
  endtask

  task automatic test_uncorrectable;
    mem[8'h05] = mem[8'h05] ^ 32'h0000_0208;
    runPass(0, 0);
    cmpCount++;
    if (uncorrCount !== 16'd1 || corrCount !== 16'd0) begin
      errCount++; $display("[TB] FAIL uncorr_counts: got uncorr %0d corr %0d, expected 1 0", uncorrCount, corrCount);
    end
    cmpCount++;
    if (errIrq !== 1'b1) begin
      errCount++; $display("[TB] FAIL uncorr_irq: got %b, expected 1", errIrq);
    end
    cmpCount++;
    if (nWrites !== 0 || doneEdge !== 512) begin
      errCount++; $display("[TB] FAIL uncorr_no_write: got %0d writes done %0d, expected 0 512", nWrites, doneEdge);
    end
    cmpCount++;
    if (lastErrAddr !== 8'h05) begin
      errCount++; $display("[TB] FAIL uncorr_last_err_addr: got %h, expected 05", lastErrAddr);
    end
    mem[8'h05] = orig[8'h05];
    runPass(0, 0);
    cmpCount++;
    if (startIrq !== 1'b0 || errIrq !== 1'b0 || uncorrCount !== 16'd0) begin
      errCount++; $display("[TB] FAIL uncorr_irq_clear: got irq@start %b irq %b uncorr %0d, expected 0 0 0", startIrq, errIrq, uncorrCount);
    end
  endtask

  task automatic test_pause;
    runPass(7, 10);
    cmpCount++;
    if (pauseViol !== 0) begin
      errCount++; $display("[TB] FAIL pause_no_req: got %0d requests while paused, expected 0", pauseViol);
    end
    cmpCount++;
    if (resumeReq !== 1'b1 || resumeAddr !== 8'd3) begin
      errCount++; $display("[TB] FAIL pause_resume: got req %b addr %0d, expected req 1 addr 3", resumeReq, resumeAddr);
    end
    cmpCount++;
    if (doneEdge !== 522) begin
      errCount++; $display("[TB] FAIL pause_done_edge: got %0d, expected 522", doneEdge);
    end
  endtask

  task automatic test_reset_mid_pass;
    mem[8'h10] = mem[8'h10] ^ 32'h0000_1000;
    tick;
    nWrites = 0;
    start = 1'b1;
    tick;
    start = 1'b0;
    repeat (34) tick;
    cmpCount++;
    if (memWe !== 1'b1 || memAddr !== 8'h10) begin
      errCount++; $display("[TB] FAIL rstmid_in_write: got we %b addr %h, expected we 1 addr 10", memWe, memAddr);
    end
    rst = 1'b0;
    #1;
    cmpCount++;
    if ({memReq, memWe, memAddr, memWdata, busy, done, corrCount, uncorrCount, lastErrAddr, errIrq} !== 85'd0) begin
      errCount++; $display("[TB] FAIL rstmid_outputs: got %h, expected 0", {memReq, memWe, memAddr, memWdata, busy, done, corrCount, uncorrCount, lastErrAddr, errIrq});
    end
    tick;
    rst = 1'b1;
    tick;
    cmpCount++;
    if (nWrites !== 0 || mem[8'h10] !== (orig[8'h10] ^ 32'h0000_1000)) begin
      errCount++; $display("[TB] FAIL rstmid_write_aborted: got %0d writes word %h, expected 0 writes", nWrites, mem[8'h10]);
    end
    runPass(0, 0);
    cmpCount++;
    if (startReq !== 1'b1 || startAddr !== 8'd0) begin
      errCount++; $display("[TB] FAIL rstmid_restart_addr: got req %b addr %0d, expected req 1 addr 0", startReq, startAddr);
    end
    cmpCount++;
    if (doneEdge !== 513 || corrCount !== 16'd1 || mem[8'h10] !== orig[8'h10]) begin
      errCount++; $display("[TB] FAIL rstmid_rescrub: got done %0d corr %0d word %h, expected 513 1 %h", doneEdge, corrCount, mem[8'h10], orig[8'h10]);
    end
  endtask

  task automatic test_saturation;
    for (int a = 0; a < 8; a++) begin
      encData = 16'(a * 4099 + 77);
      #1;
      orig2[a] = encWord;
      mem2[a]  = encWord;
      if (a == 0 || a == 1 || a == 2 || a == 4 || a == 6) mem2[a] = encWord ^ (32'd1 << (a + 3));
    end
    tick;
    nWrites2  = 0;
    doneEdge2 = -1;
    start2 = 1'b1;
    tick;
    for (int e = 1; e <= 22; e++) begin
      start2 = (e == 3) || (e == 10) || (e == 20) || (e == 22);
      tick;
      if (done2 && doneEdge2 < 0) doneEdge2 = e;
    end
    start2 = 1'b0;
    cmpCount++;
    if (doneEdge2 !== 21) begin
      errCount++; $display("[TB] FAIL sat_done_edge: got %0d, expected 21", doneEdge2);
    end
    cmpCount++;
    if (corrCount2 !== 2'd3 || uncorrCount2 !== 2'd0) begin
      errCount++; $display("[TB] FAIL sat_counts: got corr %0d uncorr %0d, expected 3 0", corrCount2, uncorrCount2);
    end
    cmpCount++;
    if (nWrites2 !== 5 || lastErrAddr2 !== 3'd6 || mem2[4] !== orig2[4]) begin
      errCount++; $display("[TB] FAIL sat_writes: got %0d writes last err %0d, expected 5 writes last err 6", nWrites2, lastErrAddr2);
    end
    cmpCount++;
    if (busy2 !== 1'b0 || done2 !== 1'b0) begin
      errCount++; $display("[TB] FAIL sat_start_in_done: got busy %b done %b, expected 0 0", busy2, done2);
    end
  endtask

  initial begin
    test_reset;
    test_clean_pass;
    test_single_flip;
    test_uncorrectable;
    test_pause;
    test_reset_mid_pass;
    test_saturation;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmpCount, errCount);
    $finish;
  end
endmodule
